cpu_fabric_bridge: RTL and testbench
====================================

# cpu_fabric_bridge

Bridges a CPU custom-instruction request/response port to a column of W_CPU_IO fabric tiles. It drives each tile's OPA/OPB 4-bit operand inputs and captures the RES0/RES1/RES2 outputs after either a fixed programmed latency or a fabric-asserted done flag. It sits on the CPU side of the column, upstream of the tiles' operand inputs and downstream of their result outputs. It runs on the fabric user clock and provides valid/ready handshakes plus a timeout error.

## Interface
Parameters:
- ROWS, 8, number of W_CPU_IO tiles in the column; DATA_W = 4*ROWS.
- LAT_W, 4, width of the programmed latency field.
- TIMEOUT, 255, maximum WAIT cycles in done mode before an error response.

Ports:
- UserCLK  in  1  fabric user clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  bridge can accept; high only in IDLE.
- req_op_a  in  DATA_W  operand A.
- req_op_b  in  DATA_W  operand B.
- req_latency  in  LAT_W  0 selects done mode; L>0 selects fixed-latency mode.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  CPU accepts the response.
- rsp_lo  out  DATA_W  captured RES0 bus.
- rsp_hi  out  DATA_W  captured RES1 bus.
- rsp_status  out  DATA_W  captured RES2 bus.
- rsp_error  out  1  done-mode timeout occurred.
- fab_opa  out  DATA_W  to tile r OPA_I0..3 = bits [4r+3:4r].
- fab_opb  out  DATA_W  to tile r OPB_I0..3, same mapping.
- fab_res0, fab_res1, fab_res2  in  DATA_W  from tile r RESk_O0..3, same mapping; fab_res2[0] is the fabric done flag.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register fab_opa/fab_opb from the request, load cnt with req_latency (fixed mode) or 0 (done mode), latch the mode, go to WAIT.
- WAIT, fixed mode:
  - cnt decrements each cycle.
  - At the edge where cnt==1: capture fab_res0/1/2 into rsp_lo/hi/status, set rsp_error=0, go to RESP.
- WAIT, done mode:
  - cnt increments each cycle.
  - fab_res2[0] is ignored on the first WAIT cycle, because the fabric must see the new operands for one full cycle.
  - From the second WAIT cycle on, if fab_res2[0]==1: capture, rsp_error=0, go to RESP.
  - Else if cnt reaches TIMEOUT: capture anyway, rsp_error=1, go to RESP.
  - If done and timeout coincide, done wins and rsp_error=0.
- RESP:
  - rsp_valid=1; outputs are stable.
  - On rsp_ready: go to IDLE next cycle.
- fab_opa/fab_opb hold their last operands until the next accepted request; they are never cleared between operations.
- Reset (any time, including mid-WAIT or mid-RESP):
  - state=IDLE.
  - All outputs 0 except req_ready=1: fab_opa, fab_opb, rsp_* and rsp_valid are 0.
  - Any in-flight operation is dropped with no response.

## Timing
- Request accepted at edge E0; fab_opa/fab_opb are valid from E0 onward.
- Fixed mode, latency L: capture at edge E0+L; rsp_valid high from E0+L. L=1 gives the fabric one cycle.
- Done mode:
  - Earliest capture at E0+2.
  - Timeout capture at E0+TIMEOUT.
- With rsp_ready held high, IDLE is re-entered one cycle after rsp_valid rises. Back-to-back throughput is therefore one request per L+2 cycles.
- No combinational path from req_* or fab_res* to any output; req_ready and rsp_valid are decoded from registered state only.

## Structure
- Package cpu_fabric_bridge_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - the TILE_BITS=4 constant;
  - the DONE_BIT index (0);
  - the default TIMEOUT.
- One natural sub-module, cpu_io_wait_counter: load/decrement/increment counter with terminal and timeout flags, parameterised by width.
- The top level holds the FSM, operand registers and capture registers.

## Test plan
- Reset mid-WAIT: accept a request, assert reset at E0+1 -> next cycle req_ready=1, rsp_valid=0, fab_opa=0, and no response ever appears.
- Fixed latency: op_a=0x12345678, op_b=0x0000000F, L=3, fabric model drives RES0=op_a+op_b -> fab_opa=0x12345678 from E0; rsp_valid at E0+3 with rsp_lo=0x12345687, rsp_error=0.
- Done mode: L=0, model raises fab_res2[0] at cycle 5 -> capture at E0+5, rsp_status[0]=1, rsp_error=0. A second run with done already high at E0+1 -> capture at E0+2, not earlier.
- Timeout: L=0, TIMEOUT=16, done never asserted -> rsp_valid at E0+16 with rsp_error=1. A run with done asserted exactly at cycle 16 -> rsp_error=0.
- Backpressure: hold rsp_ready=0 for 10 cycles while fab_res* change -> rsp_lo/hi/status stay constant and req_ready stays 0; release rsp_ready -> req_ready=1 the next cycle.
- Back-to-back: two requests with L=1 and rsp_ready tied high -> second acceptance exactly 3 cycles after the first; fab_opa switches only at the second acceptance.

Source files
------------

// File: rtl/cpu_fabric_bridge_pkg.sv
// Shared types and constants for the CPU-to-fabric custom-instruction bridge.
package cpu_fabric_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Each W_CPU_IO tile takes and returns one nibble per bus.
  localparam int TILE_BITS       = 4;
  // Bit of the RES2 bus that the fabric uses as its done flag.
  localparam int DONE_BIT        = 0;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/cpu_io_wait_counter.sv
// WAIT-state counter: loads on acceptance, counts down in fixed-latency mode
// and up in done mode. Flags are decoded from the registered count only.
module cpu_io_wait_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         inc,
  output logic         zero,
  output logic         term,
  output logic         tmo
);

  localparam logic [W-1:0] ONE     = W'(1);
  // Up-count starts at 0 on the first WAIT cycle, so LIMIT-1 is the value
  // seen on the edge LIMIT cycles after acceptance.
  localparam logic [W-1:0] TMO_VAL = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Load has priority; decrement and increment are never requested together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - ONE;
    else if (inc)  cnt <= cnt + ONE;
  end

  assign zero = (cnt == '0);
  assign term = (cnt == ONE);
  assign tmo  = (cnt == TMO_VAL);

endmodule

// File: rtl/cpu_fabric_bridge.sv
// Bridges a CPU custom-instruction port to a column of W_CPU_IO tiles:
// registers operands onto the fabric, waits a fixed latency or for the
// fabric done flag (with timeout), and holds the captured results.
module cpu_fabric_bridge
  import cpu_fabric_bridge_pkg::*;
#(
  parameter  int ROWS    = 8,
  parameter  int LAT_W   = 4,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int DATA_W  = TILE_BITS * ROWS
) (
  input  logic              UserCLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_op_a,
  input  logic [DATA_W-1:0] req_op_b,
  input  logic [LAT_W-1:0]  req_latency,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [DATA_W-1:0] rsp_status,
  output logic              rsp_error,
  output logic [DATA_W-1:0] fab_opa,
  output logic [DATA_W-1:0] fab_opb,
  input  logic [DATA_W-1:0] fab_res0,
  input  logic [DATA_W-1:0] fab_res1,
  input  logic [DATA_W-1:0] fab_res2
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (LAT_W > TMO_W) ? LAT_W : TMO_W;

  state_t state_q, state_d;
  logic   fixed_q;
  logic   acc, cap, cap_err, cnt_dec, cnt_inc;
  logic   cnt_zero, cnt_term, cnt_tmo;
  logic   done;

  assign done      = fab_res2[DONE_BIT];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  cpu_io_wait_counter #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_wait_cnt (
    .clk      (UserCLK),
    .rst      (reset),
    .load     (acc),
    .load_val ((req_latency != '0) ? CNT_W'(req_latency) : '0),
    .dec      (cnt_dec),
    .inc      (cnt_inc),
    .zero     (cnt_zero),
    .term     (cnt_term),
    .tmo      (cnt_tmo)
  );

  // State register.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    cap     = 1'b0;
    cap_err = 1'b0;
    cnt_dec = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        acc     = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (fixed_q) begin
        if (cnt_term) begin
          cap     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end else begin
        // Count 0 is the first WAIT cycle: the fabric has not yet had a full
        // cycle with the new operands, so a stale done flag is ignored.
        // Done is tested before timeout so a coincident done wins.
        if (!cnt_zero && done) begin
          cap     = 1'b1;
          state_d = RESP;
        end else if (cnt_tmo) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands and mode latch on acceptance; operands persist between ops.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      fab_opa <= '0;
      fab_opb <= '0;
      fixed_q <= 1'b0;
    end else if (acc) begin
      fab_opa <= req_op_a;
      fab_opb <= req_op_b;
      fixed_q <= (req_latency != '0);
    end
  end

  // Result capture; held stable through RESP for as long as the CPU stalls.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_status <= '0;
      rsp_error  <= 1'b0;
    end else if (cap) begin
      rsp_lo     <= fab_res0;
      rsp_hi     <= fab_res1;
      rsp_status <= fab_res2;
      rsp_error  <= cap_err;
    end
  end

endmodule

// File: tb/tb_cpu_fabric_bridge.sv
// Scoreboard bench for cpu_fabric_bridge: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever rsp_valid rises.
module tb_cpu_fabric_bridge;

  localparam int ROWS = 8;
  localparam int DW   = 32;
  localparam int TMO  = 16;

  logic          UserCLK = 1'b0;
  logic          reset   = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_op_a = '0, req_op_b = '0;
  logic [3:0]    req_latency = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_lo, rsp_hi, rsp_status;
  logic          rsp_error;
  logic [DW-1:0] fab_opa, fab_opb, fab_res0, fab_res1, fab_res2;

  // Fabric model: sum, xor, and opb shifted over a done flag; noise lets the
  // bench disturb the result buses while a response is held.
  logic          done_r = 1'b0;
  logic [DW-1:0] noise  = '0;
  assign fab_res0 = fab_opa + fab_opb + noise;
  assign fab_res1 = fab_opa ^ fab_opb ^ noise;
  assign fab_res2 = {fab_opb[DW-2:0] ^ noise[DW-2:0], done_r};

  cpu_fabric_bridge #(.ROWS(ROWS), .LAT_W(4), .TIMEOUT(TMO)) dut (
    .UserCLK(UserCLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_latency(req_latency),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_status(rsp_status), .rsp_error(rsp_error),
    .fab_opa(fab_opa), .fab_opb(fab_opb),
    .fab_res0(fab_res0), .fab_res1(fab_res1), .fab_res2(fab_res2)
  );

  always #5 UserCLK = ~UserCLK;

  int cyc = 0;
  always @(posedge UserCLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] lo, hi, st;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0, resp_seen = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic dn,
                      input logic err, input int at);
    exp_t e;
    e.lo = a + b; e.hi = a ^ b; e.st = {b[DW-2:0], dn}; e.err = err; e.cyc = at;
    q.push_back(e);
  endtask

  // Monitor: compare on the rising edge of rsp_valid, then check the held
  // response stays constant and req_ready stays low while it is held.
  exp_t cur;
  logic prev_v = 1'b0;
  always @(negedge UserCLK) begin
    if (rsp_valid && !prev_v) begin
      resp_seen++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got response lo=%h, expected none", rsp_lo);
      end else begin
        cur = q.pop_front();
        chk("rsp_cycle", DW'(cyc), DW'(cur.cyc));
        chk("rsp_lo", rsp_lo, cur.lo);
        chk("rsp_hi", rsp_hi, cur.hi);
        chk("rsp_status", rsp_status, cur.st);
        chk("rsp_error", DW'(rsp_error), DW'(cur.err));
      end
    end else if (rsp_valid && q.size() >= 0 && resp_seen > 0) begin
      chk("hold_lo", rsp_lo, cur.lo);
      chk("hold_status", rsp_status, cur.st);
      chk("hold_req_ready", DW'(req_ready), '0);
    end
    prev_v <= rsp_valid;
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] l,
                       output int e0);
    int t = 0;
    @(negedge UserCLK);
    while (!req_ready && t < 400) begin @(negedge UserCLK); t++; end
    chk("req_ready_before_issue", DW'(req_ready), 32'd1);
    req_op_a = a; req_op_b = b; req_latency = l; req_valid = 1'b1;
    @(posedge UserCLK); #1;
    req_valid = 1'b0;
    e0 = cyc;
    chk("fab_opa_at_E0", fab_opa, a);
    chk("fab_opb_at_E0", fab_opb, b);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge UserCLK);
    while ((q.size() != 0 || !req_ready) && t < 400) begin @(negedge UserCLK); t++; end
    chk("drain_pending", DW'(q.size()), '0);
    chk("drain_req_ready", DW'(req_ready), 32'd1);
  endtask

  int e0, seen0;
  logic [DW-1:0] opa_b2b;

  initial begin
    // Reset state.
    #12;
    chk("rst_req_ready", DW'(req_ready), 32'd1);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_fab_opa", fab_opa, '0);
    chk("rst_fab_opb", fab_opb, '0);
    chk("rst_rsp_lo", rsp_lo, '0);
    chk("rst_rsp_error", DW'(rsp_error), '0);
    @(negedge UserCLK); reset = 1'b0;

    // Fixed latency L=3.
    issue(32'h12345678, 32'h0000000F, 4'd3, e0);
    push(32'h12345678, 32'h0000000F, 1'b0, 1'b0, e0 + 3);
    wait_idle();
    chk("fixed_lo_sum", rsp_lo, 32'h12345687);

    // Fixed latency L=1 and L=15 (boundary values of the field).
    issue(32'hA5A5_0001, 32'h0F0F_1234, 4'd1, e0);
    push(32'hA5A5_0001, 32'h0F0F_1234, 1'b0, 1'b0, e0 + 1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'h0000_0002, 4'd15, e0);
    push(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, e0 + 15);
    wait_idle();

    // Done mode: done raised so the edge E0+5 is the first to see it.
    issue(32'h0000_1111, 32'h0000_2222, 4'd0, e0);
    push(32'h0000_1111, 32'h0000_2222, 1'b1, 1'b0, e0 + 5);
    repeat (4) @(posedge UserCLK);
    #1 done_r = 1'b1;
    wait_idle();
    done_r = 1'b0;

    // Done already high before acceptance: capture no earlier than E0+2.
    done_r = 1'b1;
    issue(32'h0BAD_CAFE, 32'h1357_9BDF, 4'd0, e0);
    push(32'h0BAD_CAFE, 32'h1357_9BDF, 1'b1, 1'b0, e0 + 2);
    wait_idle();
    done_r = 1'b0;

    // Timeout: done never arrives.
    issue(32'h4444_4444, 32'h3333_3333, 4'd0, e0);
    push(32'h4444_4444, 32'h3333_3333, 1'b0, 1'b1, e0 + TMO);
    wait_idle();

    // Done coinciding with the timeout edge wins.
    issue(32'h7000_0007, 32'h0800_0080, 4'd0, e0);
    push(32'h7000_0007, 32'h0800_0080, 1'b1, 1'b0, e0 + TMO);
    repeat (TMO - 1) @(posedge UserCLK);
    #1 done_r = 1'b1;
    wait_idle();
    done_r = 1'b0;

    // Backpressure: result buses change while the response is held.
    rsp_ready = 1'b0;
    issue(32'hDEAD_0000, 32'h0000_BEEF, 4'd2, e0);
    push(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, e0 + 2);
    repeat (2) @(posedge UserCLK);
    for (int i = 0; i < 10; i++) begin
      @(negedge UserCLK);
      noise = $urandom | 32'h1;
    end
    @(negedge UserCLK);
    chk("bp_still_valid", DW'(rsp_valid), 32'd1);
    noise = '0; rsp_ready = 1'b1;
    @(posedge UserCLK); #1;
    chk("bp_release_req_ready", DW'(req_ready), 32'd1);
    chk("bp_release_rsp_valid", DW'(rsp_valid), '0);

    // Back-to-back with req_valid held: second acceptance at E0+3.
    @(negedge UserCLK);
    req_op_a = 32'h1111_1111; req_op_b = 32'h0000_0001; req_latency = 4'd1; req_valid = 1'b1;
    @(posedge UserCLK); #1;
    e0 = cyc;
    chk("b2b_opa_E0", fab_opa, 32'h1111_1111);
    push(32'h1111_1111, 32'h0000_0001, 1'b0, 1'b0, e0 + 1);
    push(32'h2222_2222, 32'h0000_0002, 1'b0, 1'b0, e0 + 4);
    req_op_a = 32'h2222_2222; req_op_b = 32'h0000_0002;
    @(posedge UserCLK); #1;
    chk("b2b_opa_E1", fab_opa, 32'h1111_1111);
    @(posedge UserCLK); #1;
    chk("b2b_opa_E2", fab_opa, 32'h1111_1111);
    chk("b2b_ready_E2", DW'(req_ready), 32'd1);
    @(posedge UserCLK); #1;
    opa_b2b = fab_opa;
    chk("b2b_opa_E3", opa_b2b, 32'h2222_2222);
    chk("b2b_accepted_E3", DW'(req_ready), '0);
    req_valid = 1'b0;
    wait_idle();

    // Reset mid-WAIT drops the operation with no response.
    issue(32'hCAFE_F00D, 32'h0000_0003, 4'd5, e0);
    seen0 = resp_seen;
    @(posedge UserCLK); #1;
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", DW'(req_ready), 32'd1);
    chk("midrst_rsp_valid", DW'(rsp_valid), '0);
    chk("midrst_fab_opa", fab_opa, '0);
    @(negedge UserCLK); reset = 1'b0;
    repeat (10) @(negedge UserCLK);
    chk("midrst_no_response", DW'(resp_seen - seen0), '0);
    chk("final_queue_empty", DW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
